ecc_uart_tx: RTL and testbench

- Buffered, parametrised successor to the single-shot Hamming(7,4) + UART TX path.
- Accepts 4-bit nibbles on a valid/ready handshake and Hamming(7,4)-encodes each one.
- Queues codeword bytes in a small FIFO, then serialises them back-to-back as 8N1/8N2 UART frames.
- Sits between user input pins and the top-level TX pin; replaces the edge-detect/start-pulse glue.

---
 rtl/ecc_uart_pkg.sv | 33 +++
 rtl/ecc_uart_fifo.sv | 90 +++++++++
 rtl/ecc_uart_tx.sv | 183 ++++++++++++++++++
 tb/tb_ecc_uart_tx.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_uart_pkg.sv
// ----------------------------------------------------------------------------
// ecc_uart_pkg
//
// Shared definitions for the buffered Hamming(7,4) UART transmitter.
//   tx_state_t        serialiser FSM states (IDLE, START, DATA, STOP)
//   DATA_BITS         data bits per UART frame
//   hamming74_encode  nibble -> 7-bit codeword {d3,d2,d1,p3,d0,p2,p1}
//                     (bit 0 of the result is p1)
// ----------------------------------------------------------------------------
package ecc_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int DATA_BITS = 8;

    // Classic Hamming(7,4): parity bits sit at the power-of-two positions
    // (1, 2, 4) of the 1-based codeword, data bits fill the rest.
    function automatic logic [6:0] hamming74_encode(input logic [3:0] d);
        logic p1;
        logic p2;
        logic p3;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p3 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p3, d[0], p2, p1};
    endfunction

endpackage

// File: rtl/ecc_uart_fifo.sv
// ----------------------------------------------------------------------------
// ecc_uart_fifo
//
// Small synchronous FIFO holding encoded codeword bytes between the nibble
// handshake and the UART serialiser. Read data is presented combinationally
// from the head entry (first-word fall-through), so a pop consumes the value
// that is visible in the same cycle.
//
// Parameters:
//   DEPTH  entries, power of two (2..16)
//   WIDTH  bits per entry
//
// Ports:
//   clk      clock, rising edge
//   rst      synchronous reset, active-high; empties the FIFO
//   push     write wr_data this cycle (ignored when full)
//   wr_data  entry to write
//   pop      consume the head entry this cycle (ignored when empty)
//   rd_data  head entry
//   full     no free entries
//   empty    no valid entries
//   level    current occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module ecc_uart_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow/underflow so an illegal request cannot move
    // pointers or the level out of step with the stored data.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign rd_data = mem[rd_ptr];

    // NOTE: the storage array is deliberately left out of reset; emptiness is
    // tracked by the pointers and level, so stale contents are never read.
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers are exactly log2(DEPTH) bits wide, so incrementing them wraps
    // modulo DEPTH without extra logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            // Simultaneous push and pop leaves the level unchanged.
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/ecc_uart_tx.sv
// ----------------------------------------------------------------------------
// ecc_uart_tx
//
// Buffered Hamming(7,4) encoder feeding a UART transmitter. Nibbles arrive on
// a valid/ready handshake, are encoded into one byte each, queued in a small
// FIFO and shifted out back-to-back as 8N1 / 8N2 frames, LSB first.
//
// Build option:
//   ECC_UART_TX_SECDED_EN  when defined, byte[7] is the XOR of byte[6:0]
//                          (extended Hamming / SECDED, even overall parity);
//                          when undefined, byte[7] is 0. Ports and timing are
//                          identical in both builds.
//
// Parameters:
//   CLKS_PER_BIT  clocks per UART bit (2..65535)
//   FIFO_DEPTH    codeword FIFO entries, power of two (2..16)
//   STOP_BITS     stop bits per frame (1 or 2)
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous reset, active-high; aborts any frame in flight
//               and discards queued codewords
//   in_valid    nibble offered
//   in_ready    a nibble can be accepted this cycle (FIFO not full)
//   in_data     nibble d3..d0
//   tx          UART serial line, idle high
//   tx_busy     high while a frame is being shifted (START..STOP)
//   frame_done  one-cycle pulse on the last clock of the final stop bit
//   fifo_level  current FIFO occupancy
// ----------------------------------------------------------------------------
module ecc_uart_tx
    import ecc_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [3:0]                    in_data,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    // One counter serves both the per-bit period and the (possibly longer)
    // stop period, so it is sized for the larger of the two.
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT * STOP_BITS);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CLKS_PER_BIT * STOP_BITS - 1);
    localparam logic [2:0]       LAST_IDX  = 3'(DATA_BITS - 1);

    // ------------------------------------------------------------------
    // Encoder
    // ------------------------------------------------------------------
    logic [6:0]           code7;
    logic [DATA_BITS-1:0] enc_byte;

    // NOTE: every signal driven here is assigned on every pass through the
    // block, so no latch can be inferred.
    always_comb begin
        code7 = hamming74_encode(in_data);
`ifdef ECC_UART_TX_SECDED_EN
        enc_byte = {^code7, code7};
`else
        enc_byte = {1'b0, code7};
`endif
    end

    // ------------------------------------------------------------------
    // Codeword FIFO
    // ------------------------------------------------------------------
    tx_state_t            state;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rd_data;

    // in_ready only reflects the current fill level; it does not look ahead
    // to a pop happening in the same cycle.
    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;
    // The head entry is consumed on the edge where the FSM leaves IDLE.
    assign fifo_pop  = (state == IDLE) && !fifo_empty;

    ecc_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .wr_data (enc_byte),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // ------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]     baud_cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;

    // The line outputs are registered from the current state, so the
    // waveform on tx trails the state register by one clock. Every frame is
    // shifted by the same amount, which keeps frame lengths and the single
    // idle clock between back-to-back frames intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            tx_busy    <= (state != IDLE);
            frame_done <= (state == STOP) && (baud_cnt == STOP_LAST);

            case (state)
                START:   tx <= 1'b0;
                DATA:    tx <= shreg[0];
                default: tx <= 1'b1;
            endcase

            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (!fifo_empty) begin
                        shreg <= fifo_rd_data;
                        state <= START;
                    end
                end

                START: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        // Shift right so the next bit (LSB first) is at [0].
                        shreg    <= {1'b0, shreg[DATA_BITS-1:1]};
                        if (bit_idx == LAST_IDX) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (baud_cnt == STOP_LAST) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_uart_tx.sv
// ----------------------------------------------------------------------------
// tb_ecc_uart_tx
//
// Two instances: A (CLKS_PER_BIT=4, 1 stop bit) and B (CLKS_PER_BIT=3,
// 2 stop bits), both FIFO_DEPTH=4. Stimulus pushes the expected byte of each
// accepted nibble into a per-instance queue; an independent monitor per
// instance decodes frames from the tx line and compares them.
// ----------------------------------------------------------------------------
module tb_ecc_uart_tx;

    localparam int A_CPB = 4;
    localparam int A_SB  = 1;
    localparam int B_CPB = 3;
    localparam int B_SB  = 2;

    logic       clk;
    logic       rst_a, rst_b;
    logic       valid_a, valid_b;
    logic       ready_a, ready_b;
    logic [3:0] data_a, data_b;
    logic       tx_a, tx_b;
    logic       busy_a, busy_b;
    logic       done_a, done_b;
    logic [2:0] level_a, level_b;

    logic [1:0] tx_v, busy_v, done_v, ready_v;
    assign tx_v    = {tx_b, tx_a};
    assign busy_v  = {busy_b, busy_a};
    assign done_v  = {done_b, done_a};
    assign ready_v = {ready_b, ready_a};

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned cyc         = 0;
    int unsigned rst_cnt   [2] = '{0, 0};
    int unsigned frames    [2] = '{0, 0};
    int unsigned starts    [2] = '{0, 0};
    int unsigned last_xfer [2] = '{0, 0};
    bit          stalled   [2] = '{1'b0, 1'b0};
    logic [9:0]  last_bits [2];
    logic [2:0]  max_lvl_a = '0;
    logic [7:0]  exp_a [$];
    logic [7:0]  exp_b [$];
    int unsigned start_t_a [$];
    int unsigned start_t_b [$];

    ecc_uart_tx #(.CLKS_PER_BIT(A_CPB), .FIFO_DEPTH(4), .STOP_BITS(A_SB)) dut_a (
        .clk(clk), .rst(rst_a), .in_valid(valid_a), .in_ready(ready_a),
        .in_data(data_a), .tx(tx_a), .tx_busy(busy_a), .frame_done(done_a),
        .fifo_level(level_a)
    );

    ecc_uart_tx #(.CLKS_PER_BIT(B_CPB), .FIFO_DEPTH(4), .STOP_BITS(B_SB)) dut_b (
        .clk(clk), .rst(rst_b), .in_valid(valid_b), .in_ready(ready_b),
        .in_data(data_b), .tx(tx_b), .tx_busy(busy_b), .frame_done(done_b),
        .fifo_level(level_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_a) rst_cnt[0] <= rst_cnt[0] + 1;
        if (rst_b) rst_cnt[1] <= rst_cnt[1] + 1;
    end

    always @(negedge clk) begin
        if (level_a > max_lvl_a) max_lvl_a <= level_a;
    end

    // Reference model: parity bits from population counts over the covered
    // data bits, codeword laid out as {d3,d2,d1,p3,d0,p2,p1}.
    function automatic logic [7:0] ref_code(input logic [3:0] d);
        logic       p1, p2, p3;
        logic [7:0] b;
        p1 = 1'($countones(d & 4'b1011) % 2);
        p2 = 1'($countones(d & 4'b1101) % 2);
        p3 = 1'($countones(d & 4'b1110) % 2);
        b  = {1'b0, d[3], d[2], d[1], p3, d[0], p2, p1};
`ifdef ECC_UART_TX_SECDED_EN
        b[7] = 1'($countones(b[6:0]) % 2);
`endif
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Offer one nibble and hold it until accepted (bounded wait).
    task automatic send(input int k, input logic [3:0] d);
        int guard;
        guard = 0;
        @(negedge clk);
        if (k == 0) begin valid_a = 1'b1; data_a = d; end
        else        begin valid_b = 1'b1; data_b = d; end
        while (ready_v[k] !== 1'b1 && guard < 4000) begin
            stalled[k] = 1'b1;
            @(negedge clk);
            guard++;
        end
        check("send_accepted", {31'd0, ready_v[k]}, 32'd1);
        if (ready_v[k] === 1'b1) begin
            if (k == 0) exp_a.push_back(ref_code(d));
            else        exp_b.push_back(ref_code(d));
            last_xfer[k] = cyc + 1;
            @(posedge clk);
            #1;
        end
        // Data is only required to be stable in the transfer cycle.
        if (k == 0) begin valid_a = 1'b0; data_a = 4'($urandom); end
        else        begin valid_b = 1'b0; data_b = 4'($urandom); end
    endtask

    task automatic wait_frames(input int k, input int unsigned target, input int budget);
        int n;
        n = 0;
        while (frames[k] < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frames_reached", frames[k], target);
    endtask

    // Decode frames from the line, sampling on falling clock edges.
    task automatic monitor(input int k, input int cpb, input int sb);
        int          fl, rc0, dn, stop_hi, busy_lo, qn;
        logic [9:0]  bits;
        logic [7:0]  exp8;
        bit          aborted;
        fl = (9 + sb) * cpb;
        forever begin
            @(negedge clk);
            if (tx_v[k] === 1'b0) begin
                starts[k]++;
                if (k == 0) start_t_a.push_back(cyc);
                else        start_t_b.push_back(cyc);
                rc0 = int'(rst_cnt[k]);
                bits = '0; dn = 0; stop_hi = 0; busy_lo = 0; aborted = 1'b0;
                for (int j = 0; j < fl; j++) begin
                    if (j > 0) @(negedge clk);
                    if (int'(rst_cnt[k]) != rc0) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (busy_v[k] !== 1'b1) busy_lo++;
                    if (done_v[k] === 1'b1) dn += (j == fl - 1) ? 1 : 100;
                    if ((j % cpb) == (cpb / 2) && (j / cpb) < 10) bits[j / cpb] = tx_v[k];
                    if (j >= 9 * cpb && tx_v[k] === 1'b1) stop_hi++;
                end
                if (!aborted) begin
                    frames[k]++;
                    last_bits[k] = bits;
                    check("frame_busy_low_clks", busy_lo, 0);
                    check("frame_done_pulses", dn, 1);
                    check("stop_high_clks", stop_hi, sb * cpb);
                    check("start_stop_levels", {30'd0, bits[9], bits[0]}, 32'd2);
                    qn = (k == 0) ? exp_a.size() : exp_b.size();
                    check("frame_was_expected", (qn > 0) ? 1 : 0, 1);
                    if (qn > 0) begin
                        exp8 = (k == 0) ? exp_a.pop_front() : exp_b.pop_front();
                        check("frame_byte", bits[8:1], exp8);
                    end
                end
            end
        end
    endtask

    initial monitor(0, A_CPB, A_SB);
    initial monitor(1, B_CPB, B_SB);

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1);
    end

    initial begin : main
        int unsigned f0, s0, sb0;
        int          n;

        // -------- reset with in_valid held high --------
        rst_a = 1'b1; rst_b = 1'b1;
        valid_a = 1'b1; data_a = 4'hF;
        valid_b = 1'b0; data_b = 4'h0;
        repeat (3) begin
            @(negedge clk);
            check("rst_tx", tx_a, 1);
            check("rst_busy", busy_a, 0);
            check("rst_level", level_a, 0);
            check("rst_ready", ready_a, 1);
            check("rst_done", done_a, 0);
        end
        rst_a = 1'b0; rst_b = 1'b0; valid_a = 1'b0;
        repeat (60) @(negedge clk);
        check("no_frame_after_rst", starts[0], 0);
        check("level_after_rst", level_a, 0);
        check("tx_idle_after_rst", tx_a, 1);

        // -------- single nibble 4'hB --------
        s0 = start_t_a.size();
        send(0, 4'hB);
        wait_frames(0, 1, 500);
        if (start_t_a.size() > s0)
            check("latency_xfer_to_start", start_t_a[s0] - last_xfer[0], 2);
        check("bits_0xB", last_bits[0], 10'b1010101010);
        check("byte_0xB", last_bits[0][8:1], 8'h55);

        // -------- single nibble 4'h1 --------
        send(0, 4'h1);
        wait_frames(0, 2, 500);
`ifdef ECC_UART_TX_SECDED_EN
        check("byte_0x1", last_bits[0][8:1], 8'h87);
`else
        check("byte_0x1", last_bits[0][8:1], 8'h07);
`endif

        // -------- burst 0..5 against a 4-deep FIFO --------
        s0 = start_t_a.size();
        f0 = frames[0];
        stalled[0] = 1'b0;
        for (int i = 0; i < 6; i++) send(0, 4'(i));
        check("burst_ready_dropped", {31'd0, stalled[0]}, 1);
        wait_frames(0, f0 + 6, 2000);
        check("burst_max_level", max_lvl_a, 4);
        if (start_t_a.size() >= s0 + 6)
            for (int i = 1; i < 6; i++)
                check("burst_start_gap", start_t_a[s0 + i] - start_t_a[s0 + i - 1],
                      (9 + A_SB) * A_CPB + 1);

        // -------- randomized traffic on A --------
        f0 = frames[0];
        for (int i = 0; i < 10; i++) begin
            n = int'($urandom_range(0, 50));
            repeat (n) @(negedge clk);
            send(0, 4'($urandom));
        end
        wait_frames(0, f0 + 10, 3000);

        // -------- B: 2 stop bits, back-to-back random burst --------
        s0 = start_t_b.size();
        f0 = frames[1];
        for (int i = 0; i < 4; i++) send(1, 4'($urandom));
        wait_frames(1, f0 + 4, 1000);
        if (start_t_b.size() >= s0 + 4)
            for (int i = 1; i < 4; i++)
                check("b_start_gap", start_t_b[s0 + i] - start_t_b[s0 + i - 1],
                      (9 + B_SB) * B_CPB + 1);

        // -------- B: randomly spaced random nibbles --------
        f0 = frames[1];
        for (int i = 0; i < 8; i++) begin
            n = int'($urandom_range(0, 60));
            repeat (n) @(negedge clk);
            send(1, 4'($urandom));
        end
        wait_frames(1, f0 + 8, 3000);

        // -------- reset asserted mid-DATA on A --------
        sb0 = starts[0];
        for (int i = 0; i < 3; i++) send(0, 4'($urandom));
        n = 0;
        while (starts[0] == sb0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("mid_rst_frame_started", starts[0], sb0 + 1);
        repeat (3 * A_CPB + 2) @(negedge clk);
        f0  = frames[0];
        sb0 = starts[0];
        rst_a = 1'b1;
        exp_a.delete();
        @(posedge clk);
        #1;
        check("mid_rst_tx", tx_a, 1);
        check("mid_rst_level", level_a, 0);
        check("mid_rst_busy", busy_a, 0);
        rst_a = 1'b0;
        repeat (200) @(negedge clk);
        check("mid_rst_no_new_start", starts[0], sb0);
        check("mid_rst_no_completion", frames[0], f0);

        check("exp_a_drained", exp_a.size(), 0);
        check("exp_b_drained", exp_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
